// File: rtl/datawidthconv_wide_to_narrow.sv
// Buffers one packet of IN_W-bit beats and drains it as OUT_W-bit byte-addressed writes, LSB lane first.
// Define DWCONV_BYTESWAP_EN to byte-reverse every output word.
module datawidthconv_wide_to_narrow #(
    parameter int unsigned IN_W       = 512,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic              snk_valid,
    input  logic [IN_W-1:0]   snk_din,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] data_addr,
    output logic [OUT_W-1:0]  data_din,
    output logic              data_we,
    input  logic              data_ready,
    output logic              data_last,
    output logic              done,
    output logic              overflow
);
    localparam int unsigned R      = IN_W / OUT_W;
    localparam int unsigned R_LOG2 = $clog2(R);
    localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned IDX_W  = DEPTH_LOG2 + R_LOG2 + 1;
    localparam int unsigned BYTES  = OUT_W / 8;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                state, state_next;
    logic [IN_W-1:0]       mem [DEPTH];
    logic [CNT_W-1:0]      beat_cnt, cnt_next, total_beats;
    logic [DEPTH_LOG2-1:0] wr_slot;
    logic                  wr_en, ovf_set, ovf_clr;
    logic                  accept, full, enter_drain, adv, gen_more;
    logic [IDX_W-1:0]      total_words, gen_idx, s1_idx, s2_idx;
    logic                  s1_valid, s2_valid;
    logic [IN_W-1:0]       s2_beat;
    logic [OUT_W-1:0]      lane_word, out_word;

    assign accept      = snk_valid & snk_ready;
    assign full        = (beat_cnt == CNT_W'(DEPTH));
    assign enter_drain = (state != DRAIN) && (state_next == DRAIN);
    assign adv         = !data_we || data_ready;
    assign total_words = IDX_W'(total_beats) << R_LOG2;
    assign gen_more    = (state == DRAIN) && (gen_idx < total_words);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Packet capture and drain sequencing
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_slot    = '0;
        cnt_next   = beat_cnt;
        ovf_set    = 1'b0;
        ovf_clr    = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (accept && snk_sop) begin
                    wr_en      = 1'b1;
                    cnt_next   = CNT_W'(1);
                    ovf_clr    = 1'b1;
                    state_next = snk_eop ? DRAIN : FILL;
                end else if (accept && (state == FILL)) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_slot  = beat_cnt[DEPTH_LOG2-1:0];
                        cnt_next = beat_cnt + CNT_W'(1);
                    end
                    if (snk_eop) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (data_we && data_ready && data_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Three-stage word pipeline (index, buffer read, output) stalls as a whole on backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snk_ready   <= 1'b1;
            done        <= 1'b0;
            overflow    <= 1'b0;
            beat_cnt    <= '0;
            total_beats <= '0;
            gen_idx     <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            s2_valid    <= 1'b0;
            s2_idx      <= '0;
            data_we     <= 1'b0;
            data_addr   <= '0;
            data_din    <= '0;
            data_last   <= 1'b0;
        end else begin
            snk_ready <= (state_next != DRAIN);
            done      <= (state == DRAIN) && (state_next == IDLE);
            beat_cnt  <= cnt_next;
            if (ovf_clr)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
            if (enter_drain) begin
                total_beats <= cnt_next;
                gen_idx     <= '0;
            end else if (adv && gen_more) begin
                gen_idx <= gen_idx + IDX_W'(1);
            end
            if (adv) begin
                s1_valid  <= gen_more;
                s1_idx    <= gen_idx;
                s2_valid  <= s1_valid;
                s2_idx    <= s1_idx;
                data_we   <= s2_valid;
                data_addr <= ADDR_W'(s2_idx) * ADDR_W'(BYTES);
                data_din  <= out_word;
                data_last <= s2_valid && (s2_idx == total_words - IDX_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_slot] <= snk_din;
        if (adv)   s2_beat <= mem[s1_idx[IDX_W-2:R_LOG2]];
    end

    always_comb begin
        lane_word = s2_beat[s2_idx[R_LOG2-1:0] * OUT_W +: OUT_W];
    end

`ifdef DWCONV_BYTESWAP_EN
    always_comb begin
        out_word = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            out_word[b*8 +: 8] = lane_word[(BYTES-1-b)*8 +: 8];
        end
    end
`else
    assign out_word = lane_word;
`endif

endmodule

// File: tb/tb_datawidthconv_wide_to_narrow.sv
// Bench for datawidthconv_wide_to_narrow: table vectors, hand sequences and random packets
// checked against a packet-level reference model.
module tb_datawidthconv_wide_to_narrow;
    localparam int IN_W   = 512;
    localparam int OUT_W  = 32;
    localparam int R      = IN_W / OUT_W;
    localparam int MAXB   = 32;
    localparam int SW_IN  = 128;
    localparam int SW_OUT = 64;

    typedef struct { logic sop; logic eop; logic [IN_W-1:0] d; } beat_t;
    typedef struct { logic [31:0] addr; logic [OUT_W-1:0] data; logic last; } word_t;
    typedef struct { int nbeats; int pat; int rmode; bit gaps; logic exp_ovf; int exp_words; } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0;
    logic [IN_W-1:0]  snk_din = '0;
    logic             snk_ready, data_we, data_last, done, overflow;
    logic             data_ready = 1'b1;
    logic [31:0]      data_addr;
    logic [OUT_W-1:0] data_din;

    logic              s_sop = 1'b0, s_eop = 1'b0, s_valid = 1'b0;
    logic [SW_IN-1:0]  s_din = '0;
    logic              s_snk_ready, s_we, s_last, s_done, s_ovf;
    logic [31:0]       s_addr;
    logic [SW_OUT-1:0] s_data;

    int checks = 0, errors = 0, cyc = 0, rmode = 0, rcnt = 0;
    int ready_viol = 0, stall_viol = 0, s_done_n = 0;
    int rise_q[$], done_q[$], last_q[$];
    word_t got_q[$], exp_q[$];
    beat_t stim[$];
    logic [31:0]       s_addr_q[$];
    logic [SW_OUT-1:0] s_data_q[$];
    logic              s_last_q[$];
    logic              p_stall = 1'b0, p_we = 1'b0, p_last = 1'b0;
    logic [31:0]       p_addr = '0;
    logic [OUT_W-1:0]  p_din = '0;
    logic              model_ovf = 1'b0;
    vec_t              vecs[5];

    datawidthconv_wide_to_narrow dut (
        .clk(clk), .reset(reset), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_valid(snk_valid),
        .snk_din(snk_din), .snk_ready(snk_ready), .data_addr(data_addr), .data_din(data_din),
        .data_we(data_we), .data_ready(data_ready), .data_last(data_last), .done(done), .overflow(overflow)
    );

    datawidthconv_wide_to_narrow #(.IN_W(SW_IN), .OUT_W(SW_OUT), .DEPTH_LOG2(2), .ADDR_W(32)) dut_small (
        .clk(clk), .reset(reset), .snk_sop(s_sop), .snk_eop(s_eop), .snk_valid(s_valid),
        .snk_din(s_din), .snk_ready(s_snk_ready), .data_addr(s_addr), .data_din(s_data),
        .data_we(s_we), .data_ready(1'b1), .data_last(s_last), .done(s_done), .overflow(s_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sink backpressure: 0 = always ready, 1 = pattern 1,0,0,1, otherwise random
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       data_ready = 1'b1;
            1:       data_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            default: data_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
    end

    // Observes transfers, stalls and pulses on the falling edge
    always @(negedge clk) begin
        if (data_we && !p_we) rise_q.push_back(cyc);
        if (p_stall && (!data_we || data_addr != p_addr || data_din != p_din || data_last != p_last))
            stall_viol++;
        if (data_we && snk_ready) ready_viol++;
        if (data_we && data_ready) begin
            got_q.push_back('{data_addr, data_din, data_last});
            if (data_last) last_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
        p_stall = data_we && !data_ready;
        p_we    = data_we;
        p_addr  = data_addr;
        p_din   = data_din;
        p_last  = data_last;
        if (s_we) begin
            s_addr_q.push_back(s_addr);
            s_data_q.push_back(s_data);
            s_last_q.push_back(s_last);
        end
        if (s_done) s_done_n++;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Packet-level model: last sop-started packet up to its eop, first MAXB beats kept
    function automatic void build_expected();
        logic [IN_W-1:0] pkt[$];
        bit open = 1'b0;
        exp_q.delete();
        foreach (stim[k]) begin
            if (stim[k].sop) begin
                pkt.delete();
                pkt.push_back(stim[k].d);
                open = 1'b1;
                model_ovf = 1'b0;
            end else if (open) begin
                if (pkt.size() < MAXB) pkt.push_back(stim[k].d);
                else model_ovf = 1'b1;
            end
            if (open && stim[k].eop) break;
        end
        foreach (pkt[b]) begin
            for (int i = 0; i < R; i++) begin
                word_t w;
                w.addr = 32'((b * R + i) * (OUT_W / 8));
                w.data = pkt[b][i*OUT_W +: OUT_W];
`ifdef DWCONV_BYTESWAP_EN
                w.data = {<<8{w.data}};
`endif
                w.last = (b == pkt.size() - 1) && (i == R - 1);
                exp_q.push_back(w);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic sop, input logic eop, input logic [IN_W-1:0] d);
        snk_valid = 1'b1;
        snk_sop   = sop;
        snk_eop   = eop;
        snk_din   = d;
        tick();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic run_stream(input string name, input bit gaps, output int nwords);
        int gbase, dbase, wbase, lbase, rv, sv, eop_cyc, t, rise_c, last_c, done_c;
        gbase = got_q.size(); dbase = done_q.size(); wbase = rise_q.size(); lbase = last_q.size();
        rv = ready_viol; sv = stall_viol; eop_cyc = 0;
        build_expected();
        foreach (stim[k]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                snk_sop = 1'($urandom_range(0, 1));
                snk_eop = 1'($urandom_range(0, 1));
                tick();
                snk_sop = 1'b0;
                snk_eop = 1'b0;
            end
            drive_beat(stim[k].sop, stim[k].eop, stim[k].d);
            if (stim[k].eop) eop_cyc = cyc;
        end
        t = 0;
        while (done_q.size() == dbase && t < 4000) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check({name, " done pulses"}, 64'(done_q.size() - dbase), 64'd1);
        nwords = got_q.size() - gbase;
        check({name, " word count"}, 64'(nwords), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < nwords; i++) begin
            check($sformatf("%s word %0d {last,addr,data}", name, i),
                  {got_q[gbase+i].last, got_q[gbase+i].addr[30:0], got_q[gbase+i].data},
                  {exp_q[i].last, exp_q[i].addr[30:0], exp_q[i].data});
        end
        rise_c = (rise_q.size() > wbase) ? rise_q[wbase] : -1;
        last_c = (last_q.size() > lbase) ? last_q[lbase] : -1;
        done_c = (done_q.size() > dbase) ? done_q[dbase] : -1;
        check({name, " first data_we cycle"}, 64'(rise_c), 64'(eop_cyc + 3));
        check({name, " data_we rises"}, 64'(rise_q.size() - wbase), 64'd1);
        check({name, " done after last"}, 64'(done_c), 64'(last_c + 1));
        check({name, " snk_ready during drain"}, 64'(ready_viol - rv), 64'd0);
        check({name, " stable under stall"}, 64'(stall_viol - sv), 64'd0);
        check({name, " overflow"}, 64'(overflow), 64'(model_ovf));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int nw, base, n_at, dbase, t;
        logic [IN_W-1:0] d;

        vecs[0] = '{2, 0, 0, 1'b0, 1'b0, 32};
        vecs[1] = '{2, 0, 1, 1'b0, 1'b0, 32};
        vecs[2] = '{1, 1, 0, 1'b0, 1'b0, 16};
        vecs[3] = '{33, 2, 0, 1'b0, 1'b1, 512};
        vecs[4] = '{3, 2, 2, 1'b1, 1'b0, 48};

        repeat (3) tick();
        check("reset snk_ready", 64'(snk_ready), 64'd1);
        check("reset data_we", 64'(data_we), 64'd0);
        check("reset data_last", 64'(data_last), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset data_addr", 64'(data_addr), 64'd0);
        check("reset data_din", 64'(data_din), 64'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[v]) begin
            stim.delete();
            rmode = vecs[v].rmode;
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                beat_t bt;
                bt.sop = (b == 0);
                bt.eop = (b == vecs[v].nbeats - 1);
                for (int i = 0; i < R; i++) begin
                    case (vecs[v].pat)
                        0:       bt.d[i*OUT_W +: OUT_W] = 32'(b * R + i);
                        1:       bt.d[i*OUT_W +: OUT_W] = 32'hA000_0000 + 32'(b * R + i);
                        default: bt.d[i*OUT_W +: OUT_W] = $urandom();
                    endcase
                end
                stim.push_back(bt);
            end
            run_stream($sformatf("vec%0d", v), vecs[v].gaps, nw);
            check($sformatf("vec%0d table words", v), 64'(nw), 64'(vecs[v].exp_words));
            check($sformatf("vec%0d table overflow", v), 64'(overflow), 64'(vecs[v].exp_ovf));
        end

        // sop restart in the middle of an unfinished packet
        rmode = 0;
        stim.delete();
        for (int b = 0; b < 4; b++) begin
            beat_t bt;
            for (int i = 0; i < R; i++) bt.d[i*OUT_W +: OUT_W] = $urandom();
            bt.sop = (b == 0) || (b == 3);
            bt.eop = (b == 3);
            stim.push_back(bt);
        end
        run_stream("restart", 1'b0, nw);
        check("restart words", 64'(nw), 64'd16);

        // reset while draining
        for (int i = 0; i < R; i++) d[i*OUT_W +: OUT_W] = $urandom();
        base = got_q.size();
        dbase = done_q.size();
        drive_beat(1'b1, 1'b1, d);
        t = 0;
        while (got_q.size() < base + 5 && t < 100) begin
            tick();
            t++;
        end
        reset = 1'b1;
        #1;
        check("abort data_we", 64'(data_we), 64'd0);
        check("abort snk_ready", 64'(snk_ready), 64'd1);
        n_at = got_q.size();
        check("abort at word", 64'(n_at - base), 64'd5);
        tick();
        tick();
        reset = 1'b0;
        repeat (40) tick();
        check("abort no further writes", 64'(got_q.size()), 64'(n_at));
        check("abort no done", 64'(done_q.size()), 64'(dbase));

        stim.delete();
        begin
            beat_t bt;
            for (int i = 0; i < R; i++) bt.d[i*OUT_W +: OUT_W] = $urandom();
            bt.sop = 1'b1;
            bt.eop = 1'b1;
            stim.push_back(bt);
        end
        run_stream("after abort", 1'b0, nw);

        // random packets with junk beats, restarts, idle gaps and backpressure
        for (int p = 0; p < 6; p++) begin
            int n, junk;
            stim.delete();
            rmode = $urandom_range(0, 2);
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                beat_t bt;
                bt.sop = 1'b0;
                bt.eop = 1'($urandom_range(0, 1));
                bt.d = {16{$urandom()}};
                stim.push_back(bt);
            end
            if ($urandom_range(0, 3) == 0) begin
                int k = $urandom_range(1, 3);
                for (int b = 0; b < k; b++) begin
                    beat_t bt;
                    bt.sop = (b == 0);
                    bt.eop = 1'b0;
                    bt.d = {16{$urandom()}};
                    stim.push_back(bt);
                end
            end
            n = $urandom_range(1, 34);
            for (int b = 0; b < n; b++) begin
                beat_t bt;
                bt.sop = (b == 0);
                bt.eop = (b == n - 1);
                for (int i = 0; i < R; i++) bt.d[i*OUT_W +: OUT_W] = $urandom();
                stim.push_back(bt);
            end
            run_stream($sformatf("rand%0d", p), 1'b1, nw);
        end

        // narrow-configuration instance: one 128-bit beat into two 64-bit words
        s_din   = 128'h1122334455667788_0102030405060708;
        s_sop   = 1'b1;
        s_eop   = 1'b1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        t = 0;
        while (s_done_n == 0 && t < 50) begin
            tick();
            t++;
        end
        check("small words", 64'(s_data_q.size()), 64'd2);
        check("small done", 64'(s_done_n), 64'd1);
        if (s_data_q.size() >= 2) begin
`ifdef DWCONV_BYTESWAP_EN
            check("small word0", s_data_q[0], 64'h0807060504030201);
            check("small word1", s_data_q[1], 64'h8877665544332211);
`else
            check("small word0", s_data_q[0], 64'h0102030405060708);
            check("small word1", s_data_q[1], 64'h1122334455667788);
`endif
            check("small addr0", 64'(s_addr_q[0]), 64'h0);
            check("small addr1", 64'(s_addr_q[1]), 64'h8);
            check("small last", {62'd0, s_last_q[1], s_last_q[0]}, 64'b10);
        end
        check("small overflow", 64'(s_ovf), 64'd0);
        check("small snk_ready", 64'(s_snk_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
